reg_spill_ctrl: RTL and testbench

REG_SPILL_CTRL -- requirements
Module: reg_spill_ctrl

---
 rtl/reg_spill_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_reg_spill_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_spill_ctrl.sv
// -----------------------------------------------------------------------------
// reg_spill_ctrl
//
// Moves a masked subset of a 16-entry, 8-bit register file to or from a
// packed save area in data memory. A spill copies registers to memory, one
// per cycle. A fill reads memory and writes registers, two cycles per
// register, because memory read data arrives one cycle after the request.
// The k-th register moved, counting from 0, always uses slot BaseAddr+k
// (mod 256). This keeps the save area dense whichever register bits are set.
//
// Optional feature macro: SPILL_ABORT_EN
//   When defined, an Abort input follows Start. Abort stops the operation
//   after the register in flight, and Done still pulses.
//
// Ports
//   CLK       clock, all state on the rising edge
//   init_n    synchronous active-low reset
//   Start     one-cycle request, honoured only while idle
//   Abort     (SPILL_ABORT_EN only) stop after the current register
//   Mode      0 = spill (registers -> memory), 1 = fill (memory -> registers)
//   BaseAddr  first memory address of the save area
//   RegMask   bit i set = register i takes part
//   RegSrc    register-file read select; RegRData returns combinationally
//   RegDest / RegWData / RegWrite   register-file write port
//   MemAddr / MemWrite / MemWData / MemRead   data-memory request
//   MemRData  memory read data, valid the cycle after MemRead
//   Busy      high in every state except IDLE
//   Done      one-cycle completion pulse
//   Count     registers moved by the current or last operation
// -----------------------------------------------------------------------------
module reg_spill_ctrl (
    input  logic        CLK,
    input  logic        init_n,
    input  logic        Start,
`ifdef SPILL_ABORT_EN
    input  logic        Abort,
`endif
    input  logic        Mode,
    input  logic [7:0]  BaseAddr,
    input  logic [15:0] RegMask,
    output logic [3:0]  RegSrc,
    input  logic [7:0]  RegRData,
    output logic [3:0]  RegDest,
    output logic [7:0]  RegWData,
    output logic        RegWrite,
    output logic [7:0]  MemAddr,
    output logic        MemWrite,
    output logic [7:0]  MemWData,
    output logic        MemRead,
    input  logic [7:0]  MemRData,
    output logic        Busy,
    output logic        Done,
    output logic [4:0]  Count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPILL     = 3'd1,
        FILL_REQ  = 3'd2,
        FILL_WAIT = 3'd3,
        FIN       = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [7:0]  base_q, base_d;
    logic [15:0] mask_q, mask_d;
    logic [4:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  cur_idx;
    logic [15:0] mask_next;
    logic [7:0]  slot_addr;
    logic        abort_hit;

    // Abort must survive a FILL_REQ -> FILL_WAIT step. The request is
    // therefore remembered until the pending register write has been made.
`ifdef SPILL_ABORT_EN
    logic abort_q, abort_d;
    assign abort_hit = Abort | abort_q;
`else
    assign abort_hit = 1'b0;
`endif

    // Lowest-index set bit. Scanning from the top down lets the lowest
    // set bit overwrite the result last.
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) lowest_set = i[3:0];
        end
    endfunction

    // m & (m-1) clears exactly the lowest set bit. No cycle is spent on
    // register bits that are clear.
    assign cur_idx   = lowest_set(mask_q);
    assign mask_next = mask_q & (mask_q - 16'd1);
    assign slot_addr = base_q + {3'b000, count_q};

    // Next-state logic and strobe decode. Every strobe is also gated by the
    // latched direction, so no state can drive the wrong port.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_d   = base_q;
        mask_d   = mask_q;
        count_d  = count_q;
`ifdef SPILL_ABORT_EN
        abort_d  = abort_q;
`endif
        RegSrc   = 4'd0;
        RegDest  = 4'd0;
        RegWData = 8'd0;
        RegWrite = 1'b0;
        MemAddr  = 8'd0;
        MemWrite = 1'b0;
        MemWData = 8'd0;
        MemRead  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    mode_d  = Mode;
                    base_d  = BaseAddr;
                    mask_d  = RegMask;
                    count_d = 5'd0;
`ifdef SPILL_ABORT_EN
                    abort_d = 1'b0;
`endif
                    if (RegMask == 16'd0) state_d = FIN;
                    else if (Mode)        state_d = FILL_REQ;
                    else                  state_d = SPILL;
                end
            end
            SPILL: begin
                RegSrc   = cur_idx;
                MemAddr  = slot_addr;
                MemWData = RegRData;
                MemWrite = !mode_q;
                mask_d   = mask_next;
                count_d  = count_q + 5'd1;
                if ((mask_next == 16'd0) || abort_hit) state_d = FIN;
            end
            FILL_REQ: begin
                MemAddr = slot_addr;
                MemRead = mode_q;
                state_d = FILL_WAIT;
`ifdef SPILL_ABORT_EN
                abort_d = abort_hit;
`endif
            end
            FILL_WAIT: begin
                RegDest  = cur_idx;
                RegWData = MemRData;
                RegWrite = mode_q;
                mask_d   = mask_next;
                count_d  = count_q + 5'd1;
                if ((mask_next == 16'd0) || abort_hit) state_d = FIN;
                else                                   state_d = FILL_REQ;
            end
            FIN: begin
                state_d = IDLE;
`ifdef SPILL_ABORT_EN
                abort_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // The state register. A reset abandons any transfer immediately.
    always_ff @(posedge CLK) begin
        if (!init_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            base_q  <= 8'd0;
            mask_q  <= 16'd0;
            count_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPILL_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPILL_ABORT_EN
            abort_q <= abort_d;
`endif
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Count = count_q;

endmodule

// File: tb/tb_reg_spill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_spill_ctrl
//
// Scoreboard bench for reg_spill_ctrl. The bench contains a register file
// and a data memory, and the DUT drives both. For every operation issued,
// a reference model steps through the set mask bits in order. For each bit
// it queues the expected register or memory write, and it also queues the
// expected Done (completion cycle and Count). A monitor pops those
// expectations whenever the DUT strobes a write or pulses Done.
// -----------------------------------------------------------------------------
module tb_reg_spill_ctrl;

    logic        CLK = 1'b0;
    logic        init_n;
    logic        Start;
    logic        Mode;
    logic [7:0]  BaseAddr;
    logic [15:0] RegMask;
    logic [3:0]  RegSrc;
    logic [7:0]  RegRData;
    logic [3:0]  RegDest;
    logic [7:0]  RegWData;
    logic        RegWrite;
    logic [7:0]  MemAddr;
    logic        MemWrite;
    logic [7:0]  MemWData;
    logic        MemRead;
    logic [7:0]  MemRData;
    logic        Busy;
    logic        Done;
    logic [4:0]  Count;
`ifdef SPILL_ABORT_EN
    logic        Abort;
`endif

    always #5 CLK = ~CLK;

    reg_spill_ctrl dut (
        .CLK      (CLK),
        .init_n   (init_n),
        .Start    (Start),
`ifdef SPILL_ABORT_EN
        .Abort    (Abort),
`endif
        .Mode     (Mode),
        .BaseAddr (BaseAddr),
        .RegMask  (RegMask),
        .RegSrc   (RegSrc),
        .RegRData (RegRData),
        .RegDest  (RegDest),
        .RegWData (RegWData),
        .RegWrite (RegWrite),
        .MemAddr  (MemAddr),
        .MemWrite (MemWrite),
        .MemWData (MemWData),
        .MemRead  (MemRead),
        .MemRData (MemRData),
        .Busy     (Busy),
        .Done     (Done),
        .Count    (Count)
    );

    typedef struct {
        logic       isReg;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [4:0] cnt;
    } done_t;

    wr_t   expWr[$];
    done_t expDone[$];
    wr_t   monW;
    done_t monD;

    logic [7:0] regs[16];
    logic [7:0] mem[256];
    logic [7:0] refRegs[16];
    logic [7:0] refMem[256];
    logic       loadMem = 1'b0;
    logic       monOn = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         lastCount = 0;

    // This process models the storage the DUT drives. Register reads are
    // combinational. Memory read data arrives one cycle after MemRead.
    assign RegRData = regs[RegSrc];

    always @(posedge CLK) begin
        cyc++;
        if (loadMem) begin
            regs = refRegs;
            mem  = refMem;
        end else begin
            if (RegWrite) regs[RegDest] = RegWData;
            if (MemWrite) mem[MemAddr] = MemWData;
            MemRData = MemRead ? mem[MemAddr] : 8'h00;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event expected=none", name);
    endtask

    // Reference model. The k-th set mask bit (counting from the lowest)
    // moves through slot base+k. Spill copies a register to memory and fill
    // copies memory to a register. At most 'limit' registers are moved, for
    // operations that are cut short.
    task automatic planOp(input logic mode, input logic [7:0] base,
                          input logic [15:0] mask, input int limit, output int n);
        wr_t        w;
        logic [7:0] a;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (mask[i] && n < limit) begin
                a = base + 8'(n);
                if (!mode) begin
                    w.isReg = 1'b0; w.addr = a; w.data = refRegs[i];
                    refMem[a] = refRegs[i];
                end else begin
                    w.isReg = 1'b1; w.addr = 8'(i); w.data = refMem[a];
                    refRegs[i] = refMem[a];
                end
                expWr.push_back(w);
                n++;
            end
        end
    endtask

    task automatic loadModels();
        @(negedge CLK);
        loadMem = 1'b1;
        @(negedge CLK);
        loadMem = 1'b0;
    endtask

    // Issue one operation. Done is expected N+1 cycles (spill) or 2N+1
    // cycles (fill) after the cycle in which Start is sampled.
    task automatic applyStimulus(input logic mode, input logic [7:0] base,
                                 input logic [15:0] mask, input int limit,
                                 input bit expectDone);
        int    n;
        done_t d;
        @(negedge CLK);
        planOp(mode, base, mask, limit, n);
        if (expectDone) begin
            d.cyc = cyc + (mode ? 2 * n : n) + 1;
            d.cnt = 5'(n);
            expDone.push_back(d);
        end
        lastCount = n;
        Mode = mode; BaseAddr = base; RegMask = mask; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        Mode = 1'($urandom); BaseAddr = 8'($urandom); RegMask = 16'($urandom);
    endtask

    task automatic waitDone(input int budget);
        int b = 0;
        while ((expDone.size() != 0 || expWr.size() != 0) && b < budget) begin
            @(negedge CLK);
            b++;
        end
        if (b >= budget) begin
            failNow("op_timeout");
            expDone.delete();
            expWr.delete();
        end
        @(negedge CLK);
        checkOutput("busy_after_op", 32'(Busy), 32'h0);
        checkOutput("count_hold", 32'(Count), 32'(lastCount));
    endtask

    // The monitor process. It checks strobe exclusivity and quiet
    // IDLE/FIN cycles, and it matches every write and Done pulse against
    // the expectation queues.
    always @(negedge CLK) begin
        if (monOn) begin
            checkOutput("single_strobe",
                        32'(int'(MemWrite) + int'(MemRead) + int'(RegWrite) <= 1), 32'h1);
            if (!Busy || Done)
                checkOutput("quiet_strobes", 32'({MemWrite, MemRead, RegWrite}), 32'h0);
            if (!Busy) checkOutput("done_while_idle", 32'(Done), 32'h0);
            if (MemWrite) begin
                if (expWr.size() == 0) failNow("unexpected_memwrite");
                else begin
                    monW = expWr.pop_front();
                    checkOutput("spill_kind", 32'(monW.isReg), 32'h0);
                    checkOutput("spill_addr", 32'(MemAddr), 32'(monW.addr));
                    checkOutput("spill_data", 32'(MemWData), 32'(monW.data));
                end
            end
            if (RegWrite) begin
                if (expWr.size() == 0) failNow("unexpected_regwrite");
                else begin
                    monW = expWr.pop_front();
                    checkOutput("fill_kind", 32'(monW.isReg), 32'h1);
                    checkOutput("fill_dest", 32'(RegDest), 32'(monW.addr));
                    checkOutput("fill_data", 32'(RegWData), 32'(monW.data));
                end
            end
            if (Done) begin
                if (expDone.size() == 0) failNow("unexpected_done");
                else begin
                    monD = expDone.pop_front();
                    checkOutput("done_cycle", 32'(cyc), 32'(monD.cyc));
                    checkOutput("done_count", 32'(Count), 32'(monD.cnt));
                    checkOutput("done_writes_drained", 32'(expWr.size()), 32'h0);
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(Busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(Done), 32'h0);
        checkOutput({tag, "_count"}, 32'(Count), 32'h0);
        checkOutput({tag, "_strobes"}, 32'({MemWrite, MemRead, RegWrite}), 32'h0);
        checkOutput({tag, "_regsel"}, 32'({RegSrc, RegDest}), 32'h0);
        checkOutput({tag, "_data"}, 32'({MemAddr, MemWData, RegWData}), 32'h0);
    endtask

    initial begin
        logic [15:0] m;
        init_n = 1'b0; Start = 1'b0; Mode = 1'b0; BaseAddr = 8'h00; RegMask = 16'h0000;
`ifdef SPILL_ABORT_EN
        Abort = 1'b0;
`endif
        for (int i = 0; i < 16; i++) refRegs[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) refMem[i] = 8'($urandom);
        repeat (2) @(negedge CLK);
        checkAllZero("reset");
        loadModels();
        init_n = 1'b1;
        monOn = 1'b1;

        $display("[TB] directed spill 0x8005 at 0x40");
        refRegs[0] = 8'h11; refRegs[2] = 8'h22; refRegs[15] = 8'hFF;
        loadModels();
        applyStimulus(1'b0, 8'h40, 16'h8005, 16, 1'b1);
        waitDone(60);
        checkOutput("spill_mem40", 32'(mem[8'h40]), 32'h11);
        checkOutput("spill_mem41", 32'(mem[8'h41]), 32'h22);
        checkOutput("spill_mem42", 32'(mem[8'h42]), 32'hFF);
        checkOutput("spill_count3", 32'(Count), 32'h3);

        $display("[TB] directed fill 0x0003 at 0xFF (wrap)");
        refMem[8'hFF] = 8'hA5; refMem[8'h00] = 8'h5A;
        loadModels();
        applyStimulus(1'b1, 8'hFF, 16'h0003, 16, 1'b1);
        waitDone(60);
        checkOutput("fill_r0", 32'(regs[0]), 32'hA5);
        checkOutput("fill_r1", 32'(regs[1]), 32'h5A);
        checkOutput("fill_count2", 32'(Count), 32'h2);

        $display("[TB] empty mask");
        applyStimulus(1'($urandom), 8'($urandom), 16'h0000, 16, 1'b1);
        waitDone(20);

        $display("[TB] full spill with ignored second Start");
        applyStimulus(1'b0, 8'h00, 16'hFFFF, 16, 1'b1);
        repeat (5) @(negedge CLK);
        Start = 1'b1; Mode = 1'b1; RegMask = 16'($urandom);
        @(negedge CLK);
        Start = 1'b0;
        waitDone(100);
        checkOutput("full_count16", 32'(Count), 32'h10);
        for (int i = 0; i < 16; i++)
            checkOutput("full_spill_slot", 32'(mem[i]), 32'(regs[i]));

        $display("[TB] reset during third fill register");
        applyStimulus(1'b1, 8'($urandom), 16'h0F0F, 2, 1'b0);
        repeat (4) @(negedge CLK);
        init_n = 1'b0;
        @(negedge CLK);
        init_n = 1'b1;
        checkAllZero("midreset");
        checkOutput("midreset_writes_done", 32'(expWr.size()), 32'h0);
        applyStimulus(1'b1, 8'($urandom), 16'h00F3, 16, 1'b1);
        waitDone(80);

`ifdef SPILL_ABORT_EN
        $display("[TB] abort during second of five fills");
        applyStimulus(1'b1, 8'($urandom), 16'h001F, 2, 1'b1);
        repeat (3) @(negedge CLK);
        Abort = 1'b1;
        @(negedge CLK);
        Abort = 1'b0;
        waitDone(60);
        checkOutput("abort_count2", 32'(Count), 32'h2);
`endif

        $display("[TB] randomized operations");
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 7))
                0:       m = 16'h0000;
                1:       m = 16'hFFFF;
                default: m = 16'($urandom);
            endcase
            applyStimulus(1'($urandom), 8'($urandom), m, 16, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                Start = 1'b1; Mode = 1'($urandom); RegMask = 16'($urandom);
                @(negedge CLK);
                Start = 1'b0;
            end
            waitDone(80);
        end

        for (int i = 0; i < 16; i++) checkOutput("final_regs", 32'(regs[i]), 32'(refRegs[i]));
        for (int i = 0; i < 256; i++) checkOutput("final_mem", 32'(mem[i]), 32'(refMem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
